// File: rtl/axi_master_pkg.sv
// Shared AXI master definitions: default bus geometry, burst encodings and
// the splitter FSM state type.
package axi_master_pkg;

  localparam int ADDR_W          = 64;
  localparam int LEN_W           = 8;
  localparam int ID_W            = 4;
  localparam int PAGE_SIZE_BYTES = 4096;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_e;

endpackage

// File: rtl/axi_seg_calc.sv
// Combinational segment sizer: largest burst from addr that stays inside one
// page, fits in an AWLEN field and does not exceed the beats still owed.
module axi_seg_calc #(
  parameter int ADDR_W          = axi_master_pkg::ADDR_W,
  parameter int LEN_W           = axi_master_pkg::LEN_W,
  parameter int TOT_W           = 16,
  parameter int PAGE_SIZE_BYTES = axi_master_pkg::PAGE_SIZE_BYTES
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [TOT_W-1:0]  remaining,
  input  logic [2:0]        size,
  output logic [TOT_W-1:0]  seg
);

  localparam int PAGE_LSB = $clog2(PAGE_SIZE_BYTES);
  // One bit above the widest operand so PAGE_SIZE_BYTES and 2**LEN_W are exact.
  localparam int W1       = (TOT_W > PAGE_LSB + 1) ? TOT_W : PAGE_LSB + 1;
  localparam int CALC_W   = ((W1 > LEN_W + 1) ? W1 : LEN_W + 1) + 1;

  logic [CALC_W-1:0] page_off;
  logic [CALC_W-1:0] room_beats;
  logic [CALC_W-1:0] max_beats;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[ADDR_W-1:PAGE_LSB];

  always_comb begin
    page_off   = CALC_W'(addr[PAGE_LSB-1:0]);
    room_beats = (CALC_W'(PAGE_SIZE_BYTES) - page_off) >> size;
    max_beats  = CALC_W'(1) << LEN_W;
    seg        = remaining;
    if (room_beats < CALC_W'(seg)) seg = TOT_W'(room_beats);
    if (max_beats < CALC_W'(seg))  seg = TOT_W'(max_beats);
  end

endmodule

// File: rtl/axi_wr_burst_splitter.sv
// Splits a user write command (start address + total beats) into INCR AW
// bursts that never cross a page and never exceed the AWLEN range.
module axi_wr_burst_splitter #(
  parameter int ADDR_W          = axi_master_pkg::ADDR_W,
  parameter int LEN_W           = axi_master_pkg::LEN_W,
  parameter int ID_W            = axi_master_pkg::ID_W,
  parameter int PAGE_SIZE_BYTES = axi_master_pkg::PAGE_SIZE_BYTES,
  parameter int TOT_W           = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [TOT_W-1:0]  cmd_beats,
  input  logic [2:0]        cmd_size,
  input  logic [ID_W-1:0]   cmd_id,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [ID_W-1:0]   awid,
  output logic              seg_last,
  output logic              cmd_err,
  output logic              busy
);

  import axi_master_pkg::*;

  split_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TOT_W-1:0]  rem_q, rem_d;
  logic [2:0]        size_q, size_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              cmd_err_q, cmd_err_d;
  logic [TOT_W-1:0]  seg;

  axi_seg_calc #(
    .ADDR_W          (ADDR_W),
    .LEN_W           (LEN_W),
    .TOT_W           (TOT_W),
    .PAGE_SIZE_BYTES (PAGE_SIZE_BYTES)
  ) u_seg_calc (
    .addr      (addr_q),
    .remaining (rem_q),
    .size      (size_q),
    .seg       (seg)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    size_d    = size_q;
    id_d      = id_q;
    cmd_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_beats == '0) begin
            cmd_err_d = 1'b1;
          end else begin
            // Align the start address down to the beat size.
            addr_d  = cmd_addr & ~((ADDR_W'(1) << cmd_size) - ADDR_W'(1));
            rem_d   = cmd_beats;
            size_d  = cmd_size;
            id_d    = cmd_id;
            state_d = ST_SPLIT;
          end
        end
      end
      ST_SPLIT: begin
        if (awready) begin
          addr_d = addr_q + (ADDR_W'(seg) << size_q);
          rem_d  = rem_q - seg;
          if (seg == rem_q) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      size_q    <= '0;
      id_q      <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      size_q    <= size_d;
      id_q      <= id_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // AW fields come straight from registers, so they hold while stalled.
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SPLIT);
  assign awvalid   = busy;
  assign awaddr    = addr_q;
  assign awlen     = LEN_W'(seg - TOT_W'(1));
  assign awsize    = size_q;
  assign awburst   = AXI_BURST_INCR;
  assign awid      = id_q;
  assign seg_last  = busy && (seg == rem_q);
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_axi_wr_burst_splitter.sv
// Bench for axi_wr_burst_splitter: directed and randomized commands against a
// page/length splitting reference model.
module tb_axi_wr_burst_splitter;

  localparam int ADDR_W = 64;
  localparam int LEN_W  = 8;
  localparam int ID_W   = 4;
  localparam int PAGE   = 4096;
  localparam int TOT_W  = 16;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [TOT_W-1:0]  cmd_beats = '0;
  logic [2:0]        cmd_size = '0;
  logic [ID_W-1:0]   cmd_id = '0;
  logic              awvalid;
  logic              awready = 1'b0;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [ID_W-1:0]   awid;
  logic              seg_last;
  logic              cmd_err;
  logic              busy;

  always #5 aclk = ~aclk;

  axi_wr_burst_splitter #(
    .ADDR_W          (ADDR_W),
    .LEN_W           (LEN_W),
    .ID_W            (ID_W),
    .PAGE_SIZE_BYTES (PAGE),
    .TOT_W           (TOT_W)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_beats (cmd_beats),
    .cmd_size  (cmd_size),
    .cmd_id    (cmd_id),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awid      (awid),
    .seg_last  (seg_last),
    .cmd_err   (cmd_err),
    .busy      (busy)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_addr[$];
  int          exp_len[$];
  bit          exp_last[$];
  logic [63:0] got_addr[$];
  int          got_len[$];
  bit          got_last[$];
  int          got_size[$];
  int          got_id[$];
  int          got_burst[$];
  int          got_cyc[$];

  // Expected burst list: walk the command, cutting at page ends and 256 beats.
  task automatic build_model(input logic [63:0] a, input int beats, input int sz);
    logic [63:0] cur;
    longint rem, room, seg;
    exp_addr.delete(); exp_len.delete(); exp_last.delete();
    cur = a & ~((64'd1 << sz) - 64'd1);
    rem = beats;
    while (rem > 0) begin
      room = (PAGE - longint'(cur[11:0])) >> sz;
      seg  = rem;
      if (room < seg) seg = room;
      if (256 < seg) seg = 256;
      exp_addr.push_back(cur);
      exp_len.push_back(int'(seg - 1));
      exp_last.push_back(seg == rem);
      cur = cur + (64'(seg) << sz);
      rem = rem - seg;
    end
  endtask

  // mode 0: awready always 1; mode 1: random awready; mode 2: awready low 5 cycles, then 1
  task automatic do_cmd(input logic [63:0] a, input int beats, input int sz, input int id,
                        input int mode, input string tag);
    int guard, cyc;
    bit done, stalled;
    logic [63:0] s_addr;
    logic [7:0]  s_len;
    logic        s_last;
    int n;
    build_model(a, beats, sz);
    got_addr.delete(); got_len.delete(); got_last.delete();
    got_size.delete(); got_id.delete(); got_burst.delete(); got_cyc.delete();
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge aclk);
      guard++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s cmd_ready_wait: got %b want 1", tag, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_addr = a; cmd_beats = TOT_W'(beats);
    cmd_size = 3'(sz); cmd_id = ID_W'(id); awready = 1'b0;
    @(negedge aclk);
    cmd_valid = 1'b0;
    total++;
    if (awvalid !== 1'b1) begin
      bad++;
      $display("FAIL %s aw_latency: awvalid got %b want 1 one cycle after accept", tag, awvalid);
    end
    cyc = 0; done = 0; stalled = 0;
    s_addr = '0; s_len = '0; s_last = 1'b0;
    while (!done && cyc < 3000) begin
      case (mode)
        0:       awready = 1'b1;
        1:       awready = 1'($urandom_range(0, 1));
        default: awready = (cyc >= 5);
      endcase
      if (stalled) begin
        total++;
        if (awaddr !== s_addr || awlen !== s_len || seg_last !== s_last) begin
          bad++;
          $display("FAIL %s stall_hold: got addr=%h len=%0d last=%b want addr=%h len=%0d last=%b",
                   tag, awaddr, awlen, seg_last, s_addr, s_len, s_last);
        end
      end
      total++;
      if (awvalid !== 1'b1) begin
        bad++;
        $display("FAIL %s awvalid_hold: got %b want 1 at cycle %0d", tag, awvalid, cyc);
        done = 1;
      end else if (awready) begin
        got_addr.push_back(awaddr);
        got_len.push_back(int'(awlen));
        got_last.push_back(seg_last);
        got_size.push_back(int'(awsize));
        got_id.push_back(int'(awid));
        got_burst.push_back(int'(awburst));
        got_cyc.push_back(cyc);
        done = seg_last;
        stalled = 0;
      end else begin
        s_addr = awaddr; s_len = awlen; s_last = seg_last;
        stalled = 1;
      end
      @(negedge aclk);
      cyc++;
    end
    awready = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: got no final segment want seg_last within 3000 cycles", tag);
    end
    total++;
    if (got_addr.size() != exp_addr.size()) begin
      bad++;
      $display("FAIL %s seg_count: got %0d want %0d", tag, got_addr.size(), exp_addr.size());
    end
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      total++;
      if (got_addr[i] !== exp_addr[i] || got_len[i] != exp_len[i] || got_last[i] != exp_last[i] ||
          got_size[i] != sz || got_id[i] != id || got_burst[i] != 1) begin
        bad++;
        $display("FAIL %s seg%0d: got addr=%h len=%0d last=%0d size=%0d id=%0d burst=%0d want addr=%h len=%0d last=%0d size=%0d id=%0d burst=1",
                 tag, i, got_addr[i], got_len[i], got_last[i], got_size[i], got_id[i], got_burst[i],
                 exp_addr[i], exp_len[i], exp_last[i], sz, id);
      end
    end
    if (mode == 0 && got_cyc.size() > 0) begin
      total++;
      if (got_cyc[got_cyc.size()-1] - got_cyc[0] != got_cyc.size() - 1) begin
        bad++;
        $display("FAIL %s throughput: got span %0d want %0d", tag,
                 got_cyc[got_cyc.size()-1] - got_cyc[0], got_cyc.size() - 1);
      end
    end
    if (mode == 2 && got_cyc.size() > 0) begin
      total++;
      if (got_cyc[0] != 5) begin
        bad++;
        $display("FAIL %s first_hs_cycle: got %0d want 5", tag, got_cyc[0]);
      end
    end
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    total++;
    if (awvalid !== 1'b0 || busy !== 1'b0 || cmd_err !== 1'b0 || seg_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got awvalid=%b busy=%b cmd_err=%b seg_last=%b want all 0",
               awvalid, busy, cmd_err, seg_last);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    total++;
    if (cmd_ready !== 1'b1 || awvalid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got cmd_ready=%b awvalid=%b want 1 0", cmd_ready, awvalid);
    end
  endtask

  task automatic test_directed;
    do_cmd(64'h1000, 16, 4, 3, 0, "single");
    do_cmd(64'h0FC0, 8, 4, 5, 0, "page_cross");
    do_cmd(64'h0, 600, 4, 9, 0, "three_segs");
    do_cmd(64'h0FC7, 8, 4, 1, 0, "unaligned");
    do_cmd(64'hFFFF_FFFF_FFFF_FF00, 40, 4, 2, 0, "addr_wrap");
    do_cmd(64'h0, 300, 0, 7, 0, "byte_beats");
  endtask

  task automatic test_stall;
    do_cmd(64'h0FC0, 8, 4, 6, 2, "stall");
  endtask

  task automatic test_zero_beats;
    int errs, aws, nrdy;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_ready_before: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_addr = 64'h2000; cmd_beats = '0; cmd_size = 3'd4;
    @(negedge aclk);
    cmd_valid = 1'b0;
    errs = 0; aws = 0; nrdy = 0;
    for (int i = 0; i < 4; i++) begin
      if (cmd_err === 1'b1) errs++;
      if (awvalid !== 1'b0) aws++;
      if (cmd_ready !== 1'b1) nrdy++;
      @(negedge aclk);
    end
    total++;
    if (errs != 1) begin
      bad++;
      $display("FAIL zero_err_pulse: got %0d cycles want 1", errs);
    end
    total++;
    if (aws != 0 || nrdy != 0) begin
      bad++;
      $display("FAIL zero_no_aw: got awvalid_cycles=%0d not_ready_cycles=%0d want 0 0", aws, nrdy);
    end
  endtask

  task automatic test_back_to_back;
    do_cmd(64'h3F80, 20, 4, 4, 0, "b2b_a");
    total++;
    if (cmd_ready !== 1'b1 || awvalid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap_a: got cmd_ready=%b awvalid=%b want 1 0", cmd_ready, awvalid);
    end
    do_cmd(64'h5000, 3, 2, 8, 0, "b2b_b");
    total++;
    if (cmd_ready !== 1'b1 || awvalid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap_b: got cmd_ready=%b awvalid=%b want 1 0", cmd_ready, awvalid);
    end
  endtask

  task automatic test_reset_mid;
    int hits;
    cmd_valid = 1'b1; cmd_addr = 64'h0; cmd_beats = TOT_W'(600); cmd_size = 3'd4; cmd_id = 4'd1;
    @(negedge aclk);
    cmd_valid = 1'b0;
    awready = 1'b1;
    @(negedge aclk);
    total++;
    if (awvalid !== 1'b1 || awaddr !== 64'h1000) begin
      bad++;
      $display("FAIL rst_mid_second: got awvalid=%b awaddr=%h want 1 0000000000001000", awvalid, awaddr);
    end
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    total++;
    if (cmd_ready !== 1'b1 || awvalid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_release: got cmd_ready=%b awvalid=%b want 1 0", cmd_ready, awvalid);
    end
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (awvalid !== 1'b0) hits++;
    end
    awready = 1'b0;
    total++;
    if (hits != 0) begin
      bad++;
      $display("FAIL rst_mid_abandon: got %0d awvalid cycles want 0", hits);
    end
  endtask

  task automatic test_random;
    logic [63:0] a;
    for (int k = 0; k < 25; k++) begin
      a = {$urandom, $urandom};
      do_cmd(a, $urandom_range(1, 700), $urandom_range(0, 4), $urandom_range(0, 15), 1, "random");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_zero_beats();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
